hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 4, meaning multiply/divide execute latency in cycles; legal range 2..15.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports RsD, RtD  input  5 each  decode-stage source registers.
REQ-005 SHALL have ports RsE, RtE, WriteRegE  input  5 each  execute-stage sources and destination.
REQ-006 SHALL have ports WriteRegM, WriteRegW  input  5 each  memory- and writeback-stage destinations.
REQ-007 SHALL have ports RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM  input  1 each  stage control bits.
REQ-008 SHALL have ports BranchD, JumpD, PCSrcD  input  1 each  decode branch, jump, branch-taken.
REQ-009 SHALL have port MulDivStartE  input  1  multi-cycle operation entering execute.
REQ-010 SHALL have port StatClr  input  1  synchronous clear of stall statistics.
REQ-011 SHALL have ports ForwardAE, ForwardBE  output  2 each  ALU operand select: 00 register file, 01 writeback result, 10 ALUOutM.
REQ-012 SHALL have ports ForwardAD, ForwardBD  output  1 each  decode comparator takes ALUOutM.
REQ-013 SHALL have ports StallF, StallD, StallE, FlushD, FlushE, FlushM  output  1 each  pipeline register holds and bubbles.
REQ-014 SHALL have ports MulDivBusy, MulDivDone  output  1 each  FSM status.
REQ-015 SHALL have port StallCycles  output  16  saturating count of cycles with StallF high.

Function
REQ-016 ForwardAE SHALL be 10 if RsE!=0, RegWriteM, WriteRegM==RsE; else 01 if RsE!=0, RegWriteW, WriteRegW==RsE; else 00 (M beats W); ForwardBE identical using RtE.
REQ-017 ForwardAD SHALL be 1 iff RsD!=0, RegWriteM, WriteRegM==RsD; ForwardBD likewise with RtD.
REQ-018 lwstall SHALL be MemtoRegE and WriteRegE!=0 and WriteRegE equal to RsD or RtD.
REQ-019 brstall SHALL be BranchD and ((RegWriteE and WriteRegE!=0 matching RsD/RtD) or (MemtoRegM and WriteRegM!=0 matching RsD/RtD)).
REQ-020 FSM states SHALL be IDLE, BUSY, DONE: IDLE->BUSY on MulDivStartE, loading 4-bit counter with MULDIV_LAT-1; BUSY decrements each cycle, ->DONE when counter==1; DONE->IDLE after one cycle.
REQ-021 MulDivStartE in BUSY or DONE SHALL be ignored; start in DONE cycle is not accepted.
REQ-022 In BUSY: StallF=StallD=StallE=1, FlushM=1, FlushE=0, FlushD=0 (muldiv has priority over lwstall/brstall and redirect).
REQ-023 Outside BUSY: StallF=StallD=FlushE=lwstall|brstall; StallE=FlushM=0; FlushD=(PCSrcD|JumpD) and not StallD.
REQ-024 MulDivBusy SHALL be 1 in BUSY; MulDivDone SHALL be 1 only in DONE; total stall SHALL be MULDIV_LAT-1 cycles.
REQ-025 StallCycles SHALL increment on each clock with StallF=1, hold at 16'hFFFF, and StatClr SHALL zero it with priority over increment.
REQ-026 Forwarding and stall outputs SHALL be combinational from inputs and FSM state (zero added latency).

Reset
REQ-027 rst_n low SHALL immediately force FSM IDLE, counter 0, StallCycles 0, and all stall/flush/status outputs 0 regardless of clk.
REQ-028 Reset asserted during BUSY SHALL abort the operation; first cycle after release SHALL be IDLE.

Structure
REQ-029 Forward encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and FSM state enum SHALL live in shared package pipe_pkg, also used by the execute forwarding muxes.
REQ-030 The multi-cycle sequencer (FSM + counter) SHALL be one sub-module, muldiv_seq; forwarding and stall logic remain in hazard_ctrl.

Verification
REQ-031 RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 -> ForwardAE=10; WriteRegM=0 with RsE=0 -> ForwardAE=00.
REQ-032 MemtoRegE=1, WriteRegE=8, RtD=8 -> StallF=StallD=FlushE=1 one cycle, StallCycles +1.
REQ-033 BranchD=1, RegWriteE=1, WriteRegE=3, RsD=3, PCSrcD=1 -> stall asserted, FlushD=0; next cycle hazard cleared -> FlushD=1.
REQ-034 MULDIV_LAT=4, MulDivStartE pulse -> MulDivBusy and StallE high exactly 3 cycles, MulDivDone 1 cycle, second start during BUSY ignored.
REQ-035 rst_n low mid-BUSY, then StallCycles at 16'hFFFF with StallF held -> outputs 0 immediately; after release counter saturates, StatClr returns 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions.
//   fwd_sel_t  - execute-stage ALU operand select encodings
//   md_state_t - multi-cycle (mul/div) sequencer states
//   ex_fwd_sel - execute forwarding priority function (memory beats writeback)
package pipe_pkg;

  localparam int REG_W    = 5;
  localparam int MD_CNT_W = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_t;

  // Register 0 is hard-wired to zero, so it never takes a forwarded value.
  // The memory stage holds the younger result, so it wins over writeback.
  function automatic fwd_sel_t ex_fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             reg_write_m,
    input logic [REG_W-1:0] write_reg_m,
    input logic             reg_write_w,
    input logic [REG_W-1:0] write_reg_w
  );
    if (src != '0 && reg_write_m && write_reg_m == src)
      return FWD_MEM;
    else if (src != '0 && reg_write_w && write_reg_w == src)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for multi-cycle multiply/divide operations.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - multi-cycle operation entering execute (ignored unless IDLE)
//   busy       - high while the operation is in flight (pipeline stalled)
//   done       - high for the single cycle after the operation completes
// Parameter MULDIV_LAT: execute latency in cycles, legal range 2..15.
// The pipeline stalls for MULDIV_LAT-1 cycles (the BUSY state).
module muldiv_seq
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MULDIV_LAT - 1);

  md_state_t             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  // State and cycle counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the counter is loaded on acceptance and BUSY ends
  // on the cycle the counter reads 1, giving MULDIV_LAT-1 BUSY cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      BUSY:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage MIPS-style core.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   RsD/RtD, RsE/RtE           - decode / execute source registers
//   WriteRegE/M/W              - destination registers per stage
//   RegWriteE/M/W, MemtoRegE/M - stage control bits
//   BranchD, JumpD, PCSrcD     - decode branch, jump, branch taken
//   MulDivStartE               - multi-cycle op entering execute
//   StatClr                    - synchronous clear of StallCycles
//   ForwardAE/BE               - ALU operand select (pipe_pkg::fwd_sel_t)
//   ForwardAD/BD               - decode comparator takes ALUOutM
//   StallF/D/E, FlushD/E/M     - pipeline register holds and bubbles
//   MulDivBusy, MulDivDone     - sequencer status
//   StallCycles                - saturating count of cycles with StallF high
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        PCSrcD,
  input  logic        MulDivStartE,
  input  logic        StatClr,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [15:0] StallCycles
);

  logic        lwstall;
  logic        brstall;
  logic        hz_stall;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_cnt_q;

  muldiv_seq #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (MulDivStartE),
    .busy  (md_busy),
    .done  (md_done)
  );

  assign MulDivBusy = md_busy;
  assign MulDivDone = md_done;

  // Execute-stage forwarding shares its priority function with the datapath muxes.
  assign ForwardAE = ex_fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  assign ForwardBE = ex_fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);

  // Decode-stage branch comparator only ever forwards from ALUOutM.
  assign ForwardAD = (RsD != '0) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (RtD != '0) && RegWriteM && (WriteRegM == RtD);

  // Load-use: the loaded value is not available until after memory.
  assign lwstall = MemtoRegE && (WriteRegE != '0) &&
                   ((WriteRegE == RsD) || (WriteRegE == RtD));

  // Branch resolves in decode, so it must wait on an ALU result still in
  // execute or a load result still in memory.
  assign brstall = BranchD &&
                   ((RegWriteE && (WriteRegE != '0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && (WriteRegM != '0) &&
                     ((WriteRegM == RsD) || (WriteRegM == RtD))));

  assign hz_stall = lwstall | brstall;

  // Stall/flush generation. A busy multi-cycle op freezes F/D/E and
  // bubbles memory, overriding data hazards and redirects. A redirect is
  // only flushed once decode is no longer stalled. Reset forces all low.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (!rst_n) begin
      StallF = 1'b0;
    end else if (md_busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = hz_stall;
      StallD = hz_stall;
      FlushE = hz_stall;
      FlushD = (PCSrcD | JumpD) & ~hz_stall;
    end
  end

  // Stall statistics: clear wins over increment, count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (StatClr)
      stall_cnt_q <= '0;
    else if (StallF && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MULDIV_LAT=4).
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] write_reg_e;
    logic [4:0] write_reg_m;
    logic [4:0] write_reg_w;
    logic       reg_write_e;
    logic       reg_write_m;
    logic       reg_write_w;
    logic       mem_to_reg_e;
    logic       mem_to_reg_m;
    logic       branch_d;
    logic       jump_d;
    logic       pc_src_d;
    logic       start;
    logic       stat_clr;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic        BranchD, JumpD, PCSrcD, MulDivStartE, StatClr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic        MulDivBusy, MulDivDone;
  logic [15:0] StallCycles;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .MULDIV_LAT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RsD          (RsD),
    .RtD          (RtD),
    .RsE          (RsE),
    .RtE          (RtE),
    .WriteRegE    (WriteRegE),
    .WriteRegM    (WriteRegM),
    .WriteRegW    (WriteRegW),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .MemtoRegM    (MemtoRegM),
    .BranchD      (BranchD),
    .JumpD        (JumpD),
    .PCSrcD       (PCSrcD),
    .MulDivStartE (MulDivStartE),
    .StatClr      (StatClr),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .ForwardAD    (ForwardAD),
    .ForwardBD    (ForwardBD),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .MulDivBusy   (MulDivBusy),
    .MulDivDone   (MulDivDone),
    .StallCycles  (StallCycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    RsD          = s.rs_d;
    RtD          = s.rt_d;
    RsE          = s.rs_e;
    RtE          = s.rt_e;
    WriteRegE    = s.write_reg_e;
    WriteRegM    = s.write_reg_m;
    WriteRegW    = s.write_reg_w;
    RegWriteE    = s.reg_write_e;
    RegWriteM    = s.reg_write_m;
    RegWriteW    = s.reg_write_w;
    MemtoRegE    = s.mem_to_reg_e;
    MemtoRegM    = s.mem_to_reg_m;
    BranchD      = s.branch_d;
    JumpD        = s.jump_d;
    PCSrcD       = s.pc_src_d;
    MulDivStartE = s.start;
    StatClr      = s.stat_clr;
    #1;
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    s = '0;
    applyStimulus(s);

    // Reset: stall outputs held low even with a load-use hazard present.
    repeat (2) nextCycle();
    s = '0; s.mem_to_reg_e = 1'b1; s.write_reg_e = 5'd8; s.rt_d = 5'd8;
    applyStimulus(s);
    checkOutput("rst_stallf", {15'd0, StallF}, 16'd0);
    checkOutput("rst_flushe", {15'd0, FlushE}, 16'd0);
    checkOutput("rst_busy", {15'd0, MulDivBusy}, 16'd0);
    checkOutput("rst_done", {15'd0, MulDivDone}, 16'd0);
    checkOutput("rst_cnt", StallCycles, 16'd0);
    nextCycle();
    rst_n = 1'b1;
    s = '0;
    applyStimulus(s);

    // Execute forwarding: memory beats writeback, then writeback, then r0.
    s = '0; s.rs_e = 5'd5; s.rt_e = 5'd5; s.reg_write_m = 1'b1; s.write_reg_m = 5'd5;
    s.reg_write_w = 1'b1; s.write_reg_w = 5'd5;
    applyStimulus(s);
    checkOutput("fwd_ae_mem", {14'd0, ForwardAE}, 16'h0002);
    checkOutput("fwd_be_mem", {14'd0, ForwardBE}, 16'h0002);
    s.reg_write_m = 1'b0;
    applyStimulus(s);
    checkOutput("fwd_ae_wb", {14'd0, ForwardAE}, 16'h0001);
    s.rt_e = 5'd9;
    applyStimulus(s);
    checkOutput("fwd_be_rf", {14'd0, ForwardBE}, 16'h0000);
    s = '0; s.reg_write_m = 1'b1; s.reg_write_w = 1'b1;
    applyStimulus(s);
    checkOutput("fwd_ae_r0", {14'd0, ForwardAE}, 16'h0000);

    // Decode forwarding to the branch comparator.
    s = '0; s.rs_d = 5'd7; s.rt_d = 5'd3; s.reg_write_m = 1'b1; s.write_reg_m = 5'd7;
    applyStimulus(s);
    checkOutput("fwd_ad", {15'd0, ForwardAD}, 16'd1);
    checkOutput("fwd_bd_none", {15'd0, ForwardBD}, 16'd0);
    s.rt_d = 5'd7; s.reg_write_m = 1'b0;
    applyStimulus(s);
    checkOutput("fwd_ad_nowrite", {15'd0, ForwardAD}, 16'd0);
    s.reg_write_m = 1'b1;
    applyStimulus(s);
    checkOutput("fwd_bd", {15'd0, ForwardBD}, 16'd1);
    checkOutput("cnt_nostall", StallCycles, 16'd0);

    // Load-use stall for one cycle.
    nextCycle();
    s = '0; s.mem_to_reg_e = 1'b1; s.write_reg_e = 5'd8; s.rt_d = 5'd8;
    applyStimulus(s);
    checkOutput("lw_stallf", {15'd0, StallF}, 16'd1);
    checkOutput("lw_stalld", {15'd0, StallD}, 16'd1);
    checkOutput("lw_flushe", {15'd0, FlushE}, 16'd1);
    checkOutput("lw_stalle", {15'd0, StallE}, 16'd0);
    checkOutput("lw_flushm", {15'd0, FlushM}, 16'd0);
    nextCycle();
    checkOutput("lw_cnt", StallCycles, 16'd1);
    s = '0; s.mem_to_reg_e = 1'b1;
    applyStimulus(s);
    checkOutput("lw_r0_nostall", {15'd0, StallF}, 16'd0);
    nextCycle();
    checkOutput("lw_r0_cnt", StallCycles, 16'd1);

    // Branch on an execute-stage result: stall first, then redirect flush.
    s = '0; s.branch_d = 1'b1; s.reg_write_e = 1'b1; s.write_reg_e = 5'd3;
    s.rs_d = 5'd3; s.pc_src_d = 1'b1;
    applyStimulus(s);
    checkOutput("br_stallf", {15'd0, StallF}, 16'd1);
    checkOutput("br_flushd_held", {15'd0, FlushD}, 16'd0);
    nextCycle();
    s.reg_write_e = 1'b0;
    applyStimulus(s);
    checkOutput("br_clear_stallf", {15'd0, StallF}, 16'd0);
    checkOutput("br_flushd", {15'd0, FlushD}, 16'd1);
    checkOutput("br_cnt", StallCycles, 16'd2);
    nextCycle();
    s = '0; s.branch_d = 1'b1; s.mem_to_reg_m = 1'b1; s.write_reg_m = 5'd4; s.rt_d = 5'd4;
    applyStimulus(s);
    checkOutput("br_mem_stalld", {15'd0, StallD}, 16'd1);
    nextCycle();
    checkOutput("br_mem_cnt", StallCycles, 16'd3);
    s = '0; s.jump_d = 1'b1;
    applyStimulus(s);
    checkOutput("jump_flushd", {15'd0, FlushD}, 16'd1);
    checkOutput("jump_stallf", {15'd0, StallF}, 16'd0);
    nextCycle();

    // Multi-cycle op: 3 BUSY cycles, 1 DONE, starts in BUSY/DONE ignored.
    s = '0; s.start = 1'b1;
    applyStimulus(s);
    checkOutput("md_idle_busy", {15'd0, MulDivBusy}, 16'd0);
    nextCycle();
    checkOutput("md_busy1", {15'd0, MulDivBusy}, 16'd1);
    s = '0; s.mem_to_reg_e = 1'b1; s.write_reg_e = 5'd8; s.rt_d = 5'd8; s.pc_src_d = 1'b1;
    applyStimulus(s);
    checkOutput("md_stalle", {15'd0, StallE}, 16'd1);
    checkOutput("md_stallf", {15'd0, StallF}, 16'd1);
    checkOutput("md_flushm", {15'd0, FlushM}, 16'd1);
    checkOutput("md_flushe", {15'd0, FlushE}, 16'd0);
    checkOutput("md_flushd", {15'd0, FlushD}, 16'd0);
    nextCycle();
    checkOutput("md_busy2", {15'd0, MulDivBusy}, 16'd1);
    s = '0; s.start = 1'b1;
    applyStimulus(s);
    nextCycle();
    checkOutput("md_busy3", {15'd0, MulDivBusy}, 16'd1);
    checkOutput("md_done_early", {15'd0, MulDivDone}, 16'd0);
    s = '0;
    applyStimulus(s);
    nextCycle();
    checkOutput("md_busy_end", {15'd0, MulDivBusy}, 16'd0);
    checkOutput("md_done", {15'd0, MulDivDone}, 16'd1);
    checkOutput("md_done_stalle", {15'd0, StallE}, 16'd0);
    s = '0; s.start = 1'b1;
    applyStimulus(s);
    nextCycle();
    checkOutput("md_after_done", {15'd0, MulDivDone}, 16'd0);
    checkOutput("md_start_in_done", {15'd0, MulDivBusy}, 16'd0);
    s = '0;
    applyStimulus(s);
    nextCycle();
    checkOutput("md_idle_again", {15'd0, MulDivBusy}, 16'd0);
    checkOutput("md_cnt", StallCycles, 16'd6);

    // Asynchronous reset in the middle of BUSY.
    s = '0; s.start = 1'b1;
    applyStimulus(s);
    nextCycle();
    checkOutput("rb_busy", {15'd0, MulDivBusy}, 16'd1);
    s = '0;
    applyStimulus(s);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rb_busy_abort", {15'd0, MulDivBusy}, 16'd0);
    checkOutput("rb_stallf", {15'd0, StallF}, 16'd0);
    checkOutput("rb_flushm", {15'd0, FlushM}, 16'd0);
    checkOutput("rb_cnt", StallCycles, 16'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rb_idle_busy", {15'd0, MulDivBusy}, 16'd0);
    checkOutput("rb_idle_done", {15'd0, MulDivDone}, 16'd0);

    // Saturation, clear priority, then async reset with StallF held.
    s = '0; s.mem_to_reg_e = 1'b1; s.write_reg_e = 5'd8; s.rt_d = 5'd8;
    applyStimulus(s);
    repeat (65534) nextCycle();
    checkOutput("sat_fffe", StallCycles, 16'hFFFE);
    nextCycle();
    checkOutput("sat_ffff", StallCycles, 16'hFFFF);
    nextCycle();
    checkOutput("sat_hold", StallCycles, 16'hFFFF);
    checkOutput("sat_stallf", {15'd0, StallF}, 16'd1);
    s.stat_clr = 1'b1;
    applyStimulus(s);
    nextCycle();
    checkOutput("clr_prio", StallCycles, 16'd0);
    s.stat_clr = 1'b0;
    applyStimulus(s);
    nextCycle();
    checkOutput("clr_then_inc", StallCycles, 16'd1);
    nextCycle();
    checkOutput("inc_again", StallCycles, 16'd2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst2_stallf", {15'd0, StallF}, 16'd0);
    checkOutput("rst2_stalld", {15'd0, StallD}, 16'd0);
    checkOutput("rst2_flushe", {15'd0, FlushE}, 16'd0);
    checkOutput("rst2_cnt", StallCycles, 16'd0);
    nextCycle();
    rst_n = 1'b1;
    s = '0;
    applyStimulus(s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
